// File: rtl/adder_bist.sv
// On-chip self-test engine for the 32-bit Brent_Kung adder: seven fixed edge vectors
// followed by LFSR-driven random vectors, each checked against a behavioural a+b+cin.

module Brent_Kung (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] gg;
    logic [31:0] pp;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Up-sweep builds group (G,P) at 2^k-1 positions, down-sweep fills in the rest.
    always_comb begin
        gg = g;
        pp = p;
        for (int d = 0; d < 5; d++) begin
            for (int i = (2 << d) - 1; i < 32; i += (2 << d)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                pp[i] = pp[i] & pp[i - (1 << d)];
            end
        end
        for (int d = 3; d >= 0; d--) begin
            for (int i = (2 << d) + (1 << d) - 1; i < 32; i += (2 << d)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                pp[i] = pp[i] & pp[i - (1 << d)];
            end
        end
    end

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 32; i++) begin
            c[i + 1] = gg[i] | (pp[i] & cin);
        end
    end

    assign s    = p ^ c[31:0];
    assign cout = c[32];
endmodule

module adder_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED_A      = 32'h1234_5678,
    parameter logic [31:0] SEED_B      = 32'h8765_4321
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        inject_fault,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] vec_idx,
    output logic [15:0] err_count,
    output logic [15:0] first_fail_idx,
    output logic [31:0] first_fail_a,
    output logic [31:0] first_fail_b,
    output logic        first_fail_cin
);
    typedef enum logic [1:0] {IDLE, EDGE, RAND, DONE} state_t;

    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS + 6);
    localparam logic [15:0] EDGE_LAST = 16'd6;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [64:0] edge_vec(input logic [2:0] idx);
        case (idx)
            3'd1:    return {32'h0000_0001, 32'h0000_0001, 1'b0};
            3'd2:    return {32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
            3'd3:    return {32'hAAAA_AAAA, 32'h5555_5555, 1'b1};
            3'd4:    return {32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0};
            3'd5:    return {32'h1234_5678, 32'h8765_4321, 1'b1};
            3'd6:    return {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
            default: return 65'd0;
        endcase
    endfunction

    state_t      state;
    state_t      state_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_cin;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic [31:0] lfsr_a_adv;
    logic [31:0] lfsr_b_adv;
    logic [31:0] sum;
    logic        cout;
    logic [32:0] ref_sum;
    logic [32:0] seen_sum;
    logic        mismatch;
    logic        last_vec;
    logic        start_ok;
    logic [15:0] idx_next;
    logic [15:0] err_next;
    logic [64:0] vec_next;

    Brent_Kung u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .s    (sum),
        .cout (cout)
    );

    assign busy       = (state == EDGE) || (state == RAND);
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign last_vec   = (vec_idx == LAST_IDX);
    assign ref_sum    = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
    assign seen_sum   = {cout, sum ^ {31'd0, inject_fault}};
    assign mismatch   = busy && (seen_sum != ref_sum);
    assign err_next   = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
    assign idx_next   = vec_idx + 16'd1;
    assign lfsr_a_adv = lfsr_step(lfsr_a);
    assign lfsr_b_adv = lfsr_step(lfsr_b);

    always_comb begin
        vec_next = {lfsr_a_adv, lfsr_b_adv, lfsr_a_adv[31] ^ lfsr_b_adv[0]};
        if (vec_idx < EDGE_LAST) begin
            vec_next = edge_vec(idx_next[2:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EDGE;
            EDGE:    if (vec_idx == EDGE_LAST) state_next = RAND;
            RAND:    if (last_vec) state_next = DONE;
            DONE:    if (start) state_next = EDGE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_idx        <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_cin         <= 1'b0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
        end else if (start_ok) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_idx        <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_cin         <= 1'b0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
        end else if (busy) begin
            if (mismatch) begin
                err_count <= err_next;
                if (err_count == 16'd0) begin
                    first_fail_idx <= vec_idx;
                    first_fail_a   <= op_a;
                    first_fail_b   <= op_b;
                    first_fail_cin <= op_cin;
                end
            end
            if (last_vec) begin
                done <= 1'b1;
                pass <= !mismatch && (err_count == 16'd0);
            end else begin
                vec_idx <= idx_next;
                {op_a, op_b, op_cin} <= vec_next;
                // LFSRs only step for vectors drawn from them (idx 7 onward).
                if (vec_idx >= EDGE_LAST) begin
                    lfsr_a <= lfsr_a_adv;
                    lfsr_b <= lfsr_b_adv;
                end
            end
        end
    end
endmodule
